// File: rtl/sync_fifo_w2n.sv
// Single-clock FIFO that accepts wide words and hands them out
// as RATIO narrow sub-words, MSB- or LSB-first.
module sync_fifo_w2n #(
   parameter int DIN_WIDTH   = 8,
   parameter int DOUT_WIDTH  = 4,
   parameter int WADDR_WIDTH = 4,
   parameter int FWFT_EN     = 1,
   parameter int MSB_FIFO    = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DIN_WIDTH-1:0]   din,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   almost_full,
   output logic [WADDR_WIDTH:0]   wr_count,
   output logic [DOUT_WIDTH-1:0]  dout,
   input  logic                   rd_en,
   output logic                   empty,
   output logic                   almost_empty,
   output logic [WADDR_WIDTH+$clog2(DIN_WIDTH/DOUT_WIDTH):0] rd_count
);

   localparam int RATIO = DIN_WIDTH / DOUT_WIDTH;
   localparam int SW    = $clog2(RATIO);
   localparam int DEPTH = 1 << WADDR_WIDTH;
   localparam int PW    = WADDR_WIDTH + 1;
   localparam int CW    = PW + SW;

   localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
   localparam logic [PW-1:0] DEPTH_M1 = PW'(DEPTH - 1);
   localparam logic [SW-1:0] SUB_LAST = SW'(RATIO - 1);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   logic [DIN_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [SW-1:0] sub;

   logic          wr_acc;
   logic          rd_acc;
   logic [PW-1:0] wr_ptr_n;
   logic [PW-1:0] rd_ptr_n;
   logic [PW-1:0] wcnt_n;
   logic [SW-1:0] sub_n;
   logic [CW-1:0] rcnt_n;

   function automatic logic [DOUT_WIDTH-1:0] sel(
      input logic [DIN_WIDTH-1:0] w,
      input logic [SW-1:0]        k
   );
      logic [DOUT_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (k == SW'(i)) begin
            if (MSB_FIFO != 0)
               r = w[DIN_WIDTH-1-i*DOUT_WIDTH -: DOUT_WIDTH];
            else
               r = w[i*DOUT_WIDTH +: DOUT_WIDTH];
         end
      end
      return r;
   endfunction

   // Read side sees the write pointer one edge late, so a fresh
   // word becomes readable one cycle after it was stored.
   always_comb begin
      wr_acc   = wr_en && !full;
      rd_acc   = rd_en && !empty;
      wr_ptr_n = wr_ptr + PW'(wr_acc);
      sub_n    = sub + SW'(rd_acc);
      rd_ptr_n = rd_ptr + PW'(rd_acc && (sub == SUB_LAST));
      wcnt_n   = wr_ptr_n - rd_ptr_n;
      rcnt_n   = {wr_ptr - rd_ptr_n, {SW{1'b0}}} - CW'(sub_n);
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr[WADDR_WIDTH-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         sub          <= '0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         wr_count     <= '0;
         rd_count     <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         dout         <= '0;
      end else begin
         wr_ptr       <= wr_ptr_n;
         rd_ptr       <= rd_ptr_n;
         sub          <= sub_n;
         full         <= (wcnt_n == DEPTH_P);
         almost_full  <= (wcnt_n >= DEPTH_M1);
         wr_count     <= wcnt_n;
         rd_count     <= rcnt_n;
         empty        <= (rcnt_n == '0);
         almost_empty <= (rcnt_n <= ONE_C);
         if (FWFT_EN != 0) begin
            if (rcnt_n != '0)
               dout <= sel(mem[rd_ptr_n[WADDR_WIDTH-1:0]], sub_n);
         end else if (rd_acc) begin
            dout <= sel(mem[rd_ptr[WADDR_WIDTH-1:0]], sub);
         end
      end
   end

endmodule

// File: tb/tb_sync_fifo_w2n.sv
// Bench for sync_fifo_w2n: directed scenarios plus randomized traffic
// against a nibble-queue reference model.
module tb_sync_fifo_w2n;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din, din2;
   logic       wr_en, rd_en, wr_en2, rd_en2;
   logic       full, almost_full, empty, almost_empty;
   logic       full2, almost_full2, empty2, almost_empty2;
   logic [4:0] wr_count, wr_count2;
   logic [5:0] rd_count, rd_count2;
   logic [3:0] dout, dout2;

   int checks = 0;
   int errors = 0;

   logic [3:0] vis_q[$];
   logic [3:0] pend_q[$];
   int         words_in;
   int         nib_out;
   logic [3:0] dout_m;

   sync_fifo_w2n u_dut (
      .clk(clk), .rst(rst), .din(din), .wr_en(wr_en),
      .full(full), .almost_full(almost_full), .wr_count(wr_count),
      .dout(dout), .rd_en(rd_en), .empty(empty),
      .almost_empty(almost_empty), .rd_count(rd_count)
   );

   sync_fifo_w2n #(.FWFT_EN(0), .MSB_FIFO(0)) u_dut2 (
      .clk(clk), .rst(rst), .din(din2), .wr_en(wr_en2),
      .full(full2), .almost_full(almost_full2), .wr_count(wr_count2),
      .dout(dout2), .rd_en(rd_en2), .empty(empty2),
      .almost_empty(almost_empty2), .rd_count(rd_count2)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      vis_q.delete();
      pend_q.delete();
      words_in = 0;
      nib_out  = 0;
      dout_m   = 4'h0;
   endfunction

   // Wide slots held: words written minus words fully consumed.
   function automatic int m_wcount();
      return words_in - nib_out / 2;
   endfunction

   task automatic cyc(input logic w, input logic [7:0] d, input logic r);
      logic       wa, ra;
      logic [3:0] tmp;
      wr_en = w;
      din   = d;
      rd_en = r;
      wa = w && (m_wcount() < 16);
      ra = r && (vis_q.size() > 0);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (ra) begin
            tmp = vis_q.pop_front();
            nib_out++;
         end
         foreach (pend_q[i]) vis_q.push_back(pend_q[i]);
         pend_q.delete();
         if (wa) begin
            pend_q.push_back(d[7:4]);
            pend_q.push_back(d[3:0]);
            words_in++;
         end
         if (vis_q.size() > 0) dout_m = vis_q[0];
      end
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_aempty got %b want 1", almost_empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull got %b want 0", almost_full); end
      checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL rst_wrcnt got %0d want 0", wr_count); end
      checks++; if (rd_count !== 6'd0) begin errors++; $display("FAIL rst_rdcnt got %0d want 0", rd_count); end
      checks++; if (dout !== 4'h0) begin errors++; $display("FAIL rst_dout got %h want 0", dout); end
      checks++; if (empty2 !== 1'b1) begin errors++; $display("FAIL rst_empty2 got %b want 1", empty2); end
   endtask

   task automatic test_single();
      do_reset();
      cyc(1'b1, 8'hA5, 1'b0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_lat_empty got %b want 1", empty); end
      checks++; if (wr_count !== 5'd1) begin errors++; $display("FAIL single_wrcnt got %0d want 1", wr_count); end
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", empty); end
      checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL single_ae got %b want 0", almost_empty); end
      checks++; if (rd_count !== 6'd2) begin errors++; $display("FAIL single_rdcnt got %0d want 2", rd_count); end
      checks++; if (dout !== 4'hA) begin errors++; $display("FAIL single_dout0 got %h want a", dout); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (dout !== 4'h5) begin errors++; $display("FAIL single_dout1 got %h want 5", dout); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL single_ae1 got %b want 1", almost_empty); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty2 got %b want 1", empty); end
      checks++; if (wr_count !== 5'd0) begin errors++; $display("FAIL single_wrcnt2 got %0d want 0", wr_count); end
      checks++; if (dout !== 4'h5) begin errors++; $display("FAIL single_hold got %h want 5", dout); end
   endtask

   task automatic test_lsb_std();
      do_reset();
      wr_en2 = 1'b1; din2 = 8'hA5;
      cyc(1'b0, 8'h00, 1'b0);
      wr_en2 = 1'b0;
      checks++; if (empty2 !== 1'b1) begin errors++; $display("FAIL lsb_lat_empty got %b want 1", empty2); end
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (empty2 !== 1'b0) begin errors++; $display("FAIL lsb_empty got %b want 0", empty2); end
      checks++; if (dout2 !== 4'h0) begin errors++; $display("FAIL lsb_noread got %h want 0", dout2); end
      rd_en2 = 1'b1;
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (dout2 !== 4'h5) begin errors++; $display("FAIL lsb_dout0 got %h want 5", dout2); end
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (dout2 !== 4'hA) begin errors++; $display("FAIL lsb_dout1 got %h want a", dout2); end
      checks++; if (empty2 !== 1'b1) begin errors++; $display("FAIL lsb_empty2 got %b want 1", empty2); end
      cyc(1'b0, 8'h00, 1'b0);
      rd_en2 = 1'b0;
      checks++; if (dout2 !== 4'hA) begin errors++; $display("FAIL lsb_hold got %h want a", dout2); end
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         if (i == 14) begin
            checks++; if (almost_full !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL fill_af got af=%b f=%b want af=1 f=0", almost_full, full); end
         end
         if (i == 15) begin
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
         end
      end
      checks++; if (wr_count !== 5'd16) begin errors++; $display("FAIL fill_wrcnt got %0d want 16", wr_count); end
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (rd_count !== 6'd32) begin errors++; $display("FAIL fill_rdcnt got %0d want 32", rd_count); end
   endtask

   task automatic test_drain();
      logic [3:0] exp_nib;
      for (int k = 0; k < 33; k++) begin
         if (k < 32) begin
            exp_nib = (k % 2 == 0) ? 4'h0 : 4'(k / 2);
            checks++; if (dout !== exp_nib) begin errors++; $display("FAIL drain_dout[%0d] got %h want %h", k, dout, exp_nib); end
         end
         cyc(1'b0, 8'h00, 1'b1);
         if (k == 0) begin
            checks++; if (full !== 1'b1) begin errors++; $display("FAIL drain_full1 got %b want 1", full); end
         end
         if (k == 1) begin
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full2 got %b want 0", full); end
         end
         if (k == 30) begin
            checks++; if (almost_empty !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL drain_ae got ae=%b e=%b want ae=1 e=0", almost_empty, empty); end
         end
         if (k == 31) begin
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
         end
      end
      checks++; if (rd_count !== 6'd0 || wr_count !== 5'd0) begin errors++; $display("FAIL drain_over got rd=%0d wr=%0d want 0 0", rd_count, wr_count); end
   endtask

   task automatic test_full_rw();
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i + 8'h40), 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h77, 1'b1);
      checks++; if (full !== 1'b1 || wr_count !== 5'd16) begin errors++; $display("FAIL rw_reject got f=%b wr=%0d want f=1 wr=16", full, wr_count); end
      checks++; if (rd_count !== 6'd31) begin errors++; $display("FAIL rw_rdcnt got %0d want 31", rd_count); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (full !== 1'b0 || wr_count !== 5'd15) begin errors++; $display("FAIL rw_free got f=%b wr=%0d want f=0 wr=15", full, wr_count); end
      cyc(1'b1, 8'h77, 1'b0);
      checks++; if (full !== 1'b1 || wr_count !== 5'd16) begin errors++; $display("FAIL rw_accept got f=%b wr=%0d want f=1 wr=16", full, wr_count); end
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (rd_count !== 6'd32) begin errors++; $display("FAIL rw_rdcnt2 got %0d want 32", rd_count); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (rd_count !== 6'd9) begin errors++; $display("FAIL mid_pre got %0d want 9", rd_count); end
      do_reset();
      checks++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
         errors++; $display("FAIL mid_flags got e=%b ae=%b f=%b af=%b want 1 1 0 0", empty, almost_empty, full, almost_full); end
      checks++; if (wr_count !== 5'd0 || rd_count !== 6'd0 || dout !== 4'h0) begin
         errors++; $display("FAIL mid_cnt got wr=%0d rd=%0d d=%h want 0 0 0", wr_count, rd_count, dout); end
      cyc(1'b1, 8'h3C, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (dout !== 4'h3 || rd_count !== 6'd2) begin errors++; $display("FAIL mid_d0 got d=%h rd=%0d want 3 2", dout, rd_count); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (dout !== 4'hC) begin errors++; $display("FAIL mid_d1 got %h want c", dout); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %b want 1", empty); end
   endtask

   task automatic test_random();
      logic w, r;
      int   wp, rp;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         wp = ((i / 150) % 2 == 0) ? 80 : 25;
         rp = ((i / 150) % 2 == 0) ? 35 : 85;
         w = ($urandom_range(0, 99) < wp);
         r = ($urandom_range(0, 99) < rp);
         cyc(w, 8'($urandom), r);
         checks++; if (wr_count !== 5'(m_wcount())) begin errors++; $display("FAIL rnd_wrcnt[%0d] got %0d want %0d", i, wr_count, m_wcount()); end
         checks++; if (rd_count !== 6'(vis_q.size())) begin errors++; $display("FAIL rnd_rdcnt[%0d] got %0d want %0d", i, rd_count, vis_q.size()); end
         checks++; if (full !== (m_wcount() == 16)) begin errors++; $display("FAIL rnd_full[%0d] got %b", i, full); end
         checks++; if (almost_full !== (m_wcount() >= 15)) begin errors++; $display("FAIL rnd_afull[%0d] got %b", i, almost_full); end
         checks++; if (empty !== (vis_q.size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d] got %b", i, empty); end
         checks++; if (almost_empty !== (vis_q.size() <= 1)) begin errors++; $display("FAIL rnd_aempty[%0d] got %b", i, almost_empty); end
         checks++; if (dout !== dout_m) begin errors++; $display("FAIL rnd_dout[%0d] got %h want %h", i, dout, dout_m); end
      end
   endtask

   initial begin
      rst = 1'b0;
      din = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
      din2 = 8'h00; wr_en2 = 1'b0; rd_en2 = 1'b0;
      model_reset();
      #2;
      test_reset();
      test_single();
      test_lsb_std();
      test_fill();
      test_drain();
      test_full_rw();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_w2n.md
Name: sync_fifo_w2n

Overview:
- Synchronous single-clock FIFO with width down-conversion: wide words written, narrow words read.
- Each written DIN_WIDTH word is split into RATIO = DIN_WIDTH/DOUT_WIDTH sub-words, delivered in MSB- or LSB-first order.
- Counterpart of the narrow-to-wide packing FIFO; sits between wide producers (bus/DMA side) and narrow serialising consumers.

Parameters:
- DIN_WIDTH, 8: write word width. DIN_WIDTH/DOUT_WIDTH must be a power of 2, ≥2.
- DOUT_WIDTH, 4: read word width.
- WADDR_WIDTH, 4: storage depth DEPTH = 2^WADDR_WIDTH wide words.
- FWFT_EN, 1: 1 = first-word fall-through, 0 = standard read.
- MSB_FIFO, 1: 1 = most significant sub-word read first, 0 = least significant first.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  DIN_WIDTH  write data.
- wr_en  in  1  write request.
- full  out  1  no free wide slot.
- almost_full  out  1  at most one free wide slot.
- wr_count  out  WADDR_WIDTH+1  wide words stored, including a partially read word.
- dout  out  DOUT_WIDTH  read data.
- rd_en  in  1  read request.
- empty  out  1  no narrow word available.
- almost_empty  out  1  at most one narrow word available.
- rd_count  out  WADDR_WIDTH+log2(RATIO)+1  narrow words available.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears wr/rd pointers and the sub-word index.
  - Outputs: full=0, almost_full=0, wr_count=0, empty=1, almost_empty=1, rd_count=0, dout=0.
  - Applies mid-operation; in-flight data is discarded.
- Write acceptance:
  - A write is accepted iff wr_en && !full at the edge. din is stored at the wr pointer, and the pointer increments modulo DEPTH.
  - wr_en while full is ignored: no state change, no error flag.
- Read acceptance:
  - A read is accepted iff rd_en && !empty at the edge. The sub-word index advances 0..RATIO-1.
  - When the index wraps from RATIO-1 to 0, the rd pointer increments and the wide slot is freed.
  - rd_en while empty is ignored.
- Sub-word selection:
  - MSB_FIFO=1: index k selects din[DIN_WIDTH-1-k*DOUT_WIDTH -: DOUT_WIDTH].
  - MSB_FIFO=0: index k selects din[k*DOUT_WIDTH +: DOUT_WIDTH].
- Flag and count timing:
  - All flags and counts are registered and reflect state after the edge.
  - full = (wr_count == DEPTH). almost_full = (wr_count ≥ DEPTH-1).
  - rd_count = wr_count*RATIO - subidx. empty = (rd_count == 0). almost_empty = (rd_count ≤ 1).
  - A wide slot counts as occupied until its last sub-word has been read.
- Latency:
  - A write accepted at edge N makes empty fall after edge N+1, in both modes.
  - FWFT_EN=1: dout shows the head sub-word whenever empty=0. An accepted read at edge M presents the next sub-word after edge M (0 extra cycles). dout holds its last value when empty.
  - FWFT_EN=0: dout updates after the edge at which a read is accepted (1-cycle read latency), and holds otherwise.
- Simultaneous read and write:
  - Both are evaluated against flags from the start of the cycle.
  - When full, the write is rejected even if the read frees a slot in that cycle. full falls after that edge.
  - When the FIFO holds only one narrow word (empty=0), the read is accepted. The new word becomes readable per the write-to-read latency; empty may pulse high for one cycle.
- Wrap-around: pointers carry an extra MSB to distinguish full from empty. Counts stay correct across repeated wraps.

Test Plan:
- Defaults, after reset: write 0xA5 once.
  - empty falls 2 edges later; almost_empty=0, rd_count=2.
  - FWFT: dout=0xA. Read → dout=0x5, almost_empty=1. Read → empty=1, wr_count=0.
- MSB_FIFO=0, FWFT_EN=0: write 0xA5, then two reads.
  - dout=0x5 after the first read edge, 0xA after the second.
- Fill: 17 consecutive writes of 0x00..0x10.
  - almost_full=1 after the 15th, full=1 after the 16th. The 17th is ignored: wr_count=16, rd_count=32.
- Drain: continuous rd_en from full.
  - Nibbles read in order 0,0,0,1,...,0,F. full falls after the 2nd read. almost_empty after the 31st, empty after the 32nd. Further rd_en is ignored.
- Full with rd_en=1 and wr_en=1 on the same edge, din=0x77.
  - Write rejected, full still 1 after the edge. After the 2nd read, full=0; the next write of 0x77 is accepted.
- Reset mid-operation: with 5 words stored and subidx=1, assert rst one cycle.
  - All outputs at reset values. Post-reset write 0x3C reads back 0x3, 0xC with no stale data.
